// File: rtl/bist_tpg_pkg.sv
// Shared definitions for the scan BIST test-pattern generator:
// controller state encoding, LFSR geometry and feedback taps.
package bist_tpg_pkg;

    localparam int LFSR_WIDTH = 16;

    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAP_MASK = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_UNLOAD  = 3'd4,
        ST_DONE    = 3'd5
    } tpg_state_t;

    // One Fibonacci step: shift left, parity of tapped bits enters at bit 0.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(
        input logic [LFSR_WIDTH-1:0] s
    );
        return {s[LFSR_WIDTH-2:0], ^(s & LFSR_TAP_MASK)};
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// 16-bit Fibonacci LFSR pattern source.
// Load wins over shift; otherwise the register holds.
module bist_lfsr
    import bist_tpg_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] RESET_SEED = 16'hACE1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  shift,
    input  logic [LFSR_WIDTH-1:0] seed,
    output logic [LFSR_WIDTH-1:0] state
);

    // Seed on reset or load, advance one step per shift request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RESET_SEED;
        end else if (load) begin
            state <= seed;
        end else if (shift) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/bist_tpg.sv
// Scan BIST controller: sequences shift/capture/unload over the
// chain, feeds LFSR bits to scan_in and gates the response MISR.
module bist_tpg
    import bist_tpg_pkg::*;
#(
    parameter int unsigned               CHAIN_LENGTH = 8,
    parameter int unsigned               NUM_PATTERNS = 64,
    parameter logic [LFSR_WIDTH-1:0]     LFSR_SEED    = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic        scan_in,
    output logic        scan_enable,
    output logic        misr_clear,
    output logic        misr_enable,
    output logic [15:0] pattern_count,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] SHIFT_LAST = 16'(CHAIN_LENGTH - 1);
    localparam logic [15:0] PAT_TOTAL  = 16'(NUM_PATTERNS);

    tpg_state_t             state_q;
    tpg_state_t             state_d;
    logic [15:0]            shift_cnt_q;
    logic [15:0]            shift_cnt_d;
    logic [15:0]            pat_cnt_q;
    logic [15:0]            pat_cnt_d;
    logic [15:0]            pat_inc;
    logic [LFSR_WIDTH-1:0]  lfsr_state;
    logic                   lfsr_load;
    logic                   lfsr_shift;

    assign pat_inc    = pat_cnt_q + 16'd1;
    assign lfsr_load  = (state_q == ST_INIT);
    assign lfsr_shift = (state_q == ST_SHIFT);

    bist_lfsr #(
        .RESET_SEED (LFSR_SEED)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .load  (lfsr_load),
        .shift (lfsr_shift),
        .seed  (LFSR_SEED),
        .state (lfsr_state)
    );

    // State and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_cnt_q <= '0;
            pat_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            pat_cnt_q   <= pat_cnt_d;
        end
    end

    // Next-state and counter update; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        pat_cnt_d   = pat_cnt_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_INIT;
                    shift_cnt_d = '0;
                    pat_cnt_d   = '0;
                end
            end
            ST_INIT: begin
                state_d     = ST_SHIFT;
                shift_cnt_d = '0;
                pat_cnt_d   = '0;
            end
            ST_SHIFT: begin
                if (shift_cnt_q == SHIFT_LAST) begin
                    state_d     = ST_CAPTURE;
                    shift_cnt_d = '0;
                end else begin
                    shift_cnt_d = shift_cnt_q + 16'd1;
                end
            end
            ST_CAPTURE: begin
                pat_cnt_d   = pat_inc;
                shift_cnt_d = '0;
                if (pat_inc == PAT_TOTAL) begin
                    state_d = ST_UNLOAD;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_UNLOAD: begin
                if (shift_cnt_q == SHIFT_LAST) begin
                    state_d     = ST_DONE;
                    shift_cnt_d = '0;
                end else begin
                    shift_cnt_d = shift_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_d     = ST_IDLE;
            shift_cnt_d = '0;
            pat_cnt_d   = pat_cnt_q;
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        scan_in       = 1'b0;
        scan_enable   = 1'b0;
        misr_clear    = 1'b0;
        misr_enable   = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        pattern_count = pat_cnt_q;
        unique case (state_q)
            ST_INIT: begin
                misr_clear = 1'b1;
                busy       = 1'b1;
            end
            ST_SHIFT: begin
                scan_in     = lfsr_state[LFSR_WIDTH-1];
                scan_enable = 1'b1;
                misr_enable = (pat_cnt_q != 16'd0);
                busy        = 1'b1;
            end
            ST_CAPTURE: begin
                busy = 1'b1;
            end
            ST_UNLOAD: begin
                scan_enable = 1'b1;
                misr_enable = 1'b1;
                busy        = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bist_tpg.sv
// Self-checking bench for bist_tpg: directed runs plus random
// start/abort/reset traffic against a table-driven run model.
module tb_bist_tpg;

    localparam int CL      = 4;
    localparam int NP      = 2;
    localparam int RUN_LEN = 1 + NP * (CL + 1) + CL + 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        scan_in;
    logic        scan_enable;
    logic        misr_clear;
    logic        misr_enable;
    logic [15:0] pattern_count;
    logic        busy;
    logic        done;

    bist_tpg #(
        .CHAIN_LENGTH (CL),
        .NUM_PATTERNS (NP),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .scan_in       (scan_in),
        .scan_enable   (scan_enable),
        .misr_clear    (misr_clear),
        .misr_enable   (misr_enable),
        .pattern_count (pattern_count),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected outputs of one complete run, one entry per cycle after
    // start: {scan_enable, scan_in, misr_clear, misr_enable, busy, done, count}
    logic [21:0] run_tab [RUN_LEN];
    int          pos;
    logic [15:0] held_pc;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] outs();
        return {scan_enable, scan_in, misr_clear, misr_enable,
                busy, done, pattern_count};
    endfunction

    function automatic logic [21:0] model_outs();
        if (pos < 0) return {6'b0, held_pc};
        return run_tab[pos];
    endfunction

    task automatic build_table();
        int          k;
        logic [15:0] lv;
        logic        fb;
        k  = 0;
        lv = 16'hACE1;
        run_tab[k] = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
        k = k + 1;
        for (int p = 0; p < NP; p++) begin
            for (int b = 0; b < CL; b++) begin
                run_tab[k] = {1'b1, lv[15], 1'b0, (p >= 1), 1'b1, 1'b0,
                              16'(p)};
                k  = k + 1;
                fb = lv[15] ^ lv[13] ^ lv[12] ^ lv[10];
                lv = {lv[14:0], fb};
            end
            run_tab[k] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'(p)};
            k = k + 1;
        end
        for (int b = 0; b < CL; b++) begin
            run_tab[k] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'(NP)};
            k = k + 1;
        end
        run_tab[k] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'(NP)};
    endtask

    task automatic model_edge(input logic st, input logic ab);
        logic [21:0] cur;
        cur = model_outs();
        if (ab) begin
            held_pc = cur[15:0];
            pos     = -1;
        end else if ((pos < 0 || pos == RUN_LEN - 1) && st) begin
            pos = 0;
        end else if (pos >= 0 && pos < RUN_LEN - 1) begin
            pos++;
        end
    endtask

    task automatic step(input logic st, input logic ab, input string tag);
        start = st;
        abort = ab;
        @(posedge clock);
        model_edge(st, ab);
        #1;
        check(tag, 32'(outs()), 32'(model_outs()));
    endtask

    task automatic async_reset(input string tag);
        #3 reset = 1'b1;
        #1 check(tag, 32'(outs()), 32'd0);
        pos     = -1;
        held_pc = '0;
        #1 reset = 1'b0;
    endtask

    // Full run starting from IDLE/DONE; records per-cycle observations.
    task automatic full_run(output logic [3:0] p0, output logic [3:0] p1,
                            output logic [16:0] mev, output logic [16:0] mcv);
        p0  = '0;
        p1  = '0;
        mev = '0;
        mcv = '0;
        step(1'b1, 1'b0, "run_c1");
        mev[1] = misr_enable;
        mcv[1] = misr_clear;
        for (int c = 2; c <= 16; c++) begin
            step(1'b0, 1'b0, "run_seq");
            mev[c] = misr_enable;
            mcv[c] = misr_clear;
            if (c >= 2 && c <= 5) p0 = {p0[2:0], scan_in};
            if (c >= 7 && c <= 10) p1 = {p1[2:0], scan_in};
        end
    endtask

    initial begin
        logic [3:0]  p0;
        logic [3:0]  p1;
        logic [16:0] mev;
        logic [16:0] mcv;

        build_table();
        pos     = -1;
        held_pc = '0;
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        #7;
        check("reset_outs", 32'(outs()), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        step(1'b0, 1'b0, "idle");

        full_run(p0, p1, mev, mcv);
        check("pattern0", 32'(p0), 32'h0000_000A);
        check("pattern1", 32'(p1), 32'h0000_000C);
        check("misr_en_mask", 32'(mev), 32'h0000_F780);
        check("misr_clr_mask", 32'(mcv), 32'h0000_0002);
        check("done_flag", 32'(done), 32'd1);
        check("done_count", 32'(pattern_count), 32'd2);

        step(1'b0, 1'b0, "done_hold");
        step(1'b0, 1'b0, "done_hold");

        step(1'b1, 1'b0, "restart");
        check("restart_clr", 32'(misr_clear), 32'd1);
        check("restart_cnt", 32'(pattern_count), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        for (int c = 2; c <= 8; c++) step(1'b0, 1'b0, "pre_abort");
        step(1'b1, 1'b1, "abort");
        check("abort_se", 32'(scan_enable), 32'd0);
        check("abort_me", 32'(misr_enable), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cnt", 32'(pattern_count), 32'd1);
        step(1'b0, 1'b0, "abort_idle");

        step(1'b1, 1'b0, "rst_run_c1");
        for (int c = 2; c <= 13; c++) step(1'b0, 1'b0, "rst_run");
        async_reset("midrun_reset");
        check("midrun_done", 32'(done), 32'd0);
        step(1'b0, 1'b0, "post_reset");
        full_run(p0, p1, mev, mcv);
        check("rerun_pat0", 32'(p0), 32'h0000_000A);
        check("rerun_pat1", 32'(p1), 32'h0000_000C);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset("rnd_reset");
            step($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                 "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
